tot_readout_ctrl: RTL and testbench
===================================

# tot_readout_ctrl

Sequencing controller for one TOT encoder channel. It accepts a sampled hit from the delay line and its ripple counters, then holds the raw code and counters steady on the encoder inputs for a fixed settle window. It then captures the encoder result into a small output FIFO behind a valid/ready interface. It also holds the encoder configuration (`level`, `offset`, `selRawCode`) and applies changes only at sample boundaries, so a conversion never sees a configuration change part-way through.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `SETTLE_CYC`, 1: cycles the encoder inputs are held before the result is captured; 1..15.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: synchronous, active-low reset.
- `hit_valid` in 1: new sample offered.
- `hit_raw` in 32: thermometer raw code from the delay-line DFFs.
- `hit_cnt_a` in 3: ripple counter A.
- `hit_cnt_b` in 3: ripple counter B.
- `hit_ready` out 1: the block can accept a sample this cycle.
- `enc_a` out 32: registered raw code to the encoder `A` input.
- `enc_counter_a` out 3: registered counter A to the encoder.
- `enc_counter_b` out 3: registered counter B to the encoder.
- `enc_level` out 3: bubble-error tolerance to the encoder.
- `enc_offset` out 6: metastable-window offset to the encoder.
- `enc_sel_raw` out 1: raw/corrected code select to the encoder.
- `enc_coarse` in 3: encoder `outputCoarsePhase`.
- `enc_fine` in 6: encoder `outputFinePhase`.
- `enc_error` in 1: encoder `errorFlag`.
- `cfg_we` in 1: configuration write strobe.
- `cfg_wdata` in 10: {sel_raw, offset[5:0], level[2:0]}.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out 10: {error, coarse[2:0], fine[5:0]}; the phase value is coarse*64+fine.
- `out_ready` in 1: consumer accepts the FIFO head.
- `busy` out 1: the FSM is not in IDLE.
- `err_cnt` out 8: saturating encoder error count (see Configuration).

## Operation
FSM states are IDLE, SETTLE and STORE.

- **IDLE**
  - `hit_ready` = 1 when the FIFO count is below `FIFO_DEPTH`, else 0.
  - Accept occurs when `hit_valid` and `hit_ready` are both 1. On the accept edge:
    - `hit_raw` and the two counters are registered onto `enc_a`, `enc_counter_a` and `enc_counter_b`.
    - The shadow configuration is copied to `enc_level`, `enc_offset` and `enc_sel_raw`.
    - The settle counter is loaded with `SETTLE_CYC`.
    - The FSM goes to SETTLE.
- **SETTLE**
  - The settle counter decrements each cycle.
  - When the counter reaches 1, the FSM goes to STORE.
  - `hit_ready` = 0.
- **STORE**
  - {`enc_error`, `enc_coarse`, `enc_fine`} is pushed into the FIFO.
  - The FSM goes to IDLE.
  - `hit_ready` = 0.
- **Configuration writes**
  - `cfg_we` writes the shadow register in any state.
  - The shadow reaches the `enc_*` config outputs only on an accept edge.
  - If a write and an accept happen on the same edge, the encoder gets the old shadow value; the new value applies from the next sample.
- **FIFO**
  - Pop occurs when `out_valid` and `out_ready` are both 1.
  - A push and a pop on the same edge leave the count unchanged.
  - There is at most one conversion in flight, and accept requires free space, so STORE never finds the FIFO full. No sample is ever dropped.
- **Data path**
  - `enc_a`, `enc_counter_a` and `enc_counter_b` hold their value between samples.
  - `out_data` is the FIFO head; its value is don't-care while `out_valid` = 0.

## Timing
- **Reset values** (`rst_n` = 0 sampled at a clock edge):
  - FSM returns to IDLE; FIFO is emptied.
  - `out_valid` = 0, `busy` = 0, `err_cnt` = 0.
  - `hit_ready` = 1 in the first cycle after reset.
  - `enc_a` = 32'hC000_0000, `enc_counter_a` = 3'b011, `enc_counter_b` = 3'b010.
  - Shadow config and `enc_*` config outputs: level = 3'b011, offset = 6'b000000, sel_raw = 0.
- **Reset mid-conversion** aborts the sample; nothing is pushed.
- **Latency:** accept at edge k, push at edge k+SETTLE_CYC+1, and `out_valid` = 1 in the following cycle if the FIFO was empty.
- **Throughput:** one sample per SETTLE_CYC+2 cycles.
- **`busy`** is 1 from the cycle after the accept edge through the STORE cycle.

## Configuration
- **Macro:** `TOT_ERRCNT_EN`.
- **Defined:** `err_cnt` increments on each STORE where `enc_error` = 1 and saturates at 255. It clears only on reset.
- **Undefined:** the counter logic is absent and `err_cnt` is tied to 8'd0. The port list is identical in both builds.

## Test plan
- **Reset defaults.** Release reset with no stimulus: `enc_level` = 3, `enc_offset` = 0, `enc_a` = 32'hC000_0000, `hit_ready` = 1, `out_valid` = 0.
- **Single conversion** with SETTLE_CYC = 1. Stub encoder returns coarse = 2, fine = 17, error = 0. Accept at edge k: push at k+2 and `out_data` = 10'h091. `busy` is high for 2 cycles.
- **Backpressure.** Hold `out_ready` = 0, FIFO_DEPTH = 4, `hit_valid` held high: exactly 4 accepts, then `hit_ready` stays 0. A single pop re-enables exactly one accept.
- **Config timing.** Drive `cfg_we` with level = 1 on the same edge as an accept: that sample drives `enc_level` = 3, and the next sample drives 1.
- **Error counter** (with `TOT_ERRCNT_EN` defined). Run 300 samples with `enc_error` = 1: `err_cnt` = 255. Without the macro, `err_cnt` = 0.
- **Mid-conversion reset.** Assert reset in SETTLE: FIFO stays empty and `out_valid` stays 0. A sample after release converts normally.

Source files
------------

// File: rtl/tot_readout_ctrl.sv
// Readout sequencer for one TOT encoder channel: hit capture, settle window, result FIFO.
// Optional build macro TOT_ERRCNT_EN enables the saturating encoder-error counter.
module tot_readout_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit_valid,
  input  logic [31:0] hit_raw,
  input  logic [2:0]  hit_cnt_a,
  input  logic [2:0]  hit_cnt_b,
  output logic        hit_ready,
  output logic [31:0] enc_a,
  output logic [2:0]  enc_counter_a,
  output logic [2:0]  enc_counter_b,
  output logic [2:0]  enc_level,
  output logic [5:0]  enc_offset,
  output logic        enc_sel_raw,
  input  logic [2:0]  enc_coarse,
  input  logic [5:0]  enc_fine,
  input  logic        enc_error,
  input  logic        cfg_we,
  input  logic [9:0]  cfg_wdata,
  output logic        out_valid,
  output logic [9:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, STORE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_settle_cnt;
  logic [9:0]      r_shadow;
  logic [9:0]      r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  assign hit_ready = (r_state == IDLE) && (r_count < DEPTH_C);
  assign w_accept  = hit_valid && hit_ready;
  assign w_push    = (r_state == STORE);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_fifo_mem[r_rd_ptr];
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SETTLE;
      SETTLE:  if (r_settle_cnt <= 4'd1) w_state_next = STORE;
      STORE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 r_settle_cnt <= 4'd0;
    else if (w_accept)          r_settle_cnt <= 4'(SETTLE_CYC);
    else if (r_state == SETTLE) r_settle_cnt <= r_settle_cnt - 4'd1;
  end

  // Config is double-buffered: writes land in the shadow, the encoder sees it only per sample.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_shadow <= {1'b0, 6'b000000, 3'b011};
    else if (cfg_we) r_shadow <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_a         <= 32'hC000_0000;
      enc_counter_a <= 3'b011;
      enc_counter_b <= 3'b010;
      enc_level     <= 3'b011;
      enc_offset    <= 6'b000000;
      enc_sel_raw   <= 1'b0;
    end else if (w_accept) begin
      enc_a         <= hit_raw;
      enc_counter_a <= hit_cnt_a;
      enc_counter_b <= hit_cnt_b;
      enc_level     <= r_shadow[2:0];
      enc_offset    <= r_shadow[8:3];
      enc_sel_raw   <= r_shadow[9];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {enc_error, enc_coarse, enc_fine};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef TOT_ERRCNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)                                     r_err_cnt <= 8'd0;
    else if (w_push && enc_error && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tot_readout_ctrl.sv
// Scoreboard bench for tot_readout_ctrl: stimulus queues expected FIFO words, a monitor checks pops.
module tb_tot_readout_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hit_valid;
  logic [31:0] hit_raw;
  logic [2:0]  hit_cnt_a, hit_cnt_b;
  logic        hit_ready;
  logic [31:0] enc_a;
  logic [2:0]  enc_counter_a, enc_counter_b, enc_level;
  logic [5:0]  enc_offset;
  logic        enc_sel_raw;
  logic [2:0]  enc_coarse;
  logic [5:0]  enc_fine;
  logic        enc_error;
  logic        cfg_we;
  logic [9:0]  cfg_wdata;
  logic        out_valid;
  logic [9:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_total = 0;
  int n_pass  = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  tot_readout_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_raw(hit_raw),
    .hit_cnt_a(hit_cnt_a), .hit_cnt_b(hit_cnt_b), .hit_ready(hit_ready),
    .enc_a(enc_a), .enc_counter_a(enc_counter_a), .enc_counter_b(enc_counter_b),
    .enc_level(enc_level), .enc_offset(enc_offset), .enc_sel_raw(enc_sel_raw),
    .enc_coarse(enc_coarse), .enc_fine(enc_fine), .enc_error(enc_error),
    .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s = %h", name, act);
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge pops at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %h, expected no output", out_data);
      end else begin
        check("out_data", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int w = 0;
    while (hit_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (hit_ready !== 1'b1) begin
      n_total++;
      $display("FAIL ready_timeout: got hit_ready=%b, expected 1", hit_ready);
    end
  endtask

  task automatic do_sample(input logic [31:0] raw, input logic [2:0] ca, input logic [2:0] cb,
                           input logic [2:0] co, input logic [5:0] fi, input logic er);
    wait_ready();
    hit_raw    = raw;
    hit_cnt_a  = ca;
    hit_cnt_b  = cb;
    enc_coarse = co;
    enc_fine   = fi;
    enc_error  = er;
    hit_valid  = 1'b1;
    exp_q.push_back({er, co, fi});
    tick();
    hit_valid  = 1'b0;
  endtask

  task automatic drain;
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      tick();
      w++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; hit_valid = 1'b0; hit_raw = '0; hit_cnt_a = '0; hit_cnt_b = '0;
    enc_coarse = '0; enc_fine = '0; enc_error = 1'b0;
    cfg_we = 1'b0; cfg_wdata = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset defaults
    check("rst_hit_ready", 32'(hit_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enc_a", enc_a, 32'hC000_0000);
    check("rst_cnt_a", 32'(enc_counter_a), 32'd3);
    check("rst_cnt_b", 32'(enc_counter_b), 32'd2);
    check("rst_level", 32'(enc_level), 32'd3);
    check("rst_offset", 32'(enc_offset), 32'd0);
    check("rst_sel_raw", 32'(enc_sel_raw), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Single conversion, latency and busy window
    do_sample(32'h0000_FFFF, 3'd5, 3'd1, 3'd2, 6'd17, 1'b0);
    check("s1_busy_k", 32'(busy), 32'd1);
    check("s1_enc_a", enc_a, 32'h0000_FFFF);
    check("s1_enc_cnt_a", 32'(enc_counter_a), 32'd5);
    check("s1_enc_cnt_b", 32'(enc_counter_b), 32'd1);
    check("s1_ready_low", 32'(hit_ready), 32'd0);
    tick();
    check("s1_busy_k1", 32'(busy), 32'd1);
    check("s1_valid_k1", 32'(out_valid), 32'd0);
    tick();
    check("s1_busy_k2", 32'(busy), 32'd0);
    check("s1_valid_k2", 32'(out_valid), 32'd1);
    check("s1_head", 32'(out_data), 32'h091);
    out_ready = 1'b1;
    drain();

    // Backpressure: four accepts fill the FIFO
    out_ready = 1'b0;
    enc_coarse = 3'd3; enc_fine = 6'd5; enc_error = 1'b0;
    hit_raw = 32'h0FFF_FFFF; hit_cnt_a = 3'd1; hit_cnt_b = 3'd2;
    hit_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      if (hit_ready) begin
        acc++;
        exp_q.push_back(10'h0C5);
      end
      tick();
    end
    check("bp_accepts", 32'(acc), 32'd4);
    check("bp_ready_low", 32'(hit_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (hit_ready) begin
        acc++;
        exp_q.push_back(10'h0C5);
      end
      tick();
    end
    check("bp_one_more", 32'(acc), 32'd1);
    hit_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();
    check("bp_valid_after_drain", 32'(out_valid), 32'd0);

    // Config write coincident with accept applies from the next sample
    wait_ready();
    cfg_we = 1'b1;
    cfg_wdata = {1'b0, 6'd9, 3'd1};
    enc_coarse = 3'd4; enc_fine = 6'd0; enc_error = 1'b0;
    hit_valid = 1'b1;
    exp_q.push_back(10'h100);
    tick();
    cfg_we = 1'b0;
    hit_valid = 1'b0;
    check("cfg_same_edge_level", 32'(enc_level), 32'd3);
    check("cfg_same_edge_offset", 32'(enc_offset), 32'd0);
    do_sample(32'h0000_00FF, 3'd0, 3'd0, 3'd4, 6'd0, 1'b0);
    check("cfg_next_level", 32'(enc_level), 32'd1);
    check("cfg_next_offset", 32'(enc_offset), 32'd9);
    check("cfg_next_sel_raw", 32'(enc_sel_raw), 32'd0);
    drain();

    // Error counter saturation over 300 flagged samples
    for (int i = 0; i < 300; i++)
      do_sample(32'h0000_0FFF, 3'(i), 3'(i + 1), 3'(i), 6'(i * 3), 1'b1);
    drain();
`ifdef TOT_ERRCNT_EN
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
`else
    check("err_cnt_off", 32'(err_cnt), 32'd0);
`endif

    // Reset during SETTLE aborts the sample
    wait_ready();
    enc_coarse = 3'd1; enc_fine = 6'd1; enc_error = 1'b0;
    hit_raw = 32'hFFFF_0000;
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    check("mr_busy_settle", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_enc_a", enc_a, 32'hC000_0000);
    check("mr_err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) tick();
    check("mr_valid", 32'(out_valid), 32'd0);
    do_sample(32'h00FF_FFFF, 3'd6, 3'd7, 3'd5, 6'd33, 1'b1);
    drain();
    tick();
    check("final_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
